// File: rtl/traffic_light_if.sv
// Traffic-light code bus between a controller (master) and a monitor (slave).
interface traffic_light_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       light;
   logic             err_clear;
   logic             lamp_red;
   logic             lamp_green;
   logic             lamp_yellow;
   logic             in_sync;
   logic             phase_done;
   logic             fault;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output light, err_clear,
      input  lamp_red, lamp_green, lamp_yellow, in_sync, phase_done, fault, err_code, cycle_count
   );

   modport slave (
      input  light, err_clear,
      output lamp_red, lamp_green, lamp_yellow, in_sync, phase_done, fault, err_code, cycle_count
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Traffic-light bus monitor: lamp decode, R->G->Y->R order and dwell checking,
// completed-cycle counter and a sticky fault that forces red-only lamps.
module traffic_light_monitor #(
   parameter int DWELL = 4,
   parameter int RUN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   traffic_light_if.slave bus
);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_TRACK  = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   localparam logic [1:0]       CODE_RED     = 2'd0;
   localparam logic [1:0]       CODE_GREEN   = 2'd1;
   localparam logic [1:0]       CODE_YELLOW  = 2'd2;
   localparam logic [1:0]       CODE_ILLEGAL = 2'd3;
   localparam logic [1:0]       ERR_NONE     = 2'd0;
   localparam logic [1:0]       ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0]       ERR_ORDER    = 2'd2;
   localparam logic [1:0]       ERR_DWELL    = 2'd3;
   localparam logic [RUN_W-1:0] RUN_MAX      = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0] RUN_ONE      = RUN_W'(1);
   localparam logic [RUN_W-1:0] DWELL_RUN    = RUN_W'(DWELL);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   // {red, green, yellow}; the illegal code lights nothing
   function automatic logic [2:0] decode_lamps(input logic [1:0] code);
      logic [2:0] lamps;
      case (code)
         CODE_RED:    lamps = 3'b100;
         CODE_GREEN:  lamps = 3'b010;
         CODE_YELLOW: lamps = 3'b001;
         default:     lamps = 3'b000;
      endcase
      return lamps;
   endfunction

   function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
      logic ok;
      case ({prev, cur})
         {CODE_RED, CODE_GREEN},
         {CODE_GREEN, CODE_YELLOW},
         {CODE_YELLOW, CODE_RED}: ok = 1'b1;
         default:                 ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [1:0]       prev_code_r;
   logic [1:0]       prev_code_nxt_s;
   logic [RUN_W-1:0] run_len_r;
   logic [RUN_W-1:0] run_len_nxt_s;
   logic [1:0]       err_code_r;
   logic [1:0]       err_code_nxt_s;
   logic             change_s;
   logic             phase_done_nxt_s;
   logic             count_inc_s;
   logic [2:0]       lamps_r;
   logic             in_sync_r;
   logic             phase_done_r;
   logic             fault_r;
   logic [CNT_W-1:0] cycle_count_r;

   assign change_s = (bus.light != prev_code_r);

   // Next-state, error code, phase pulse and run-length computation
   always_comb begin
      state_nxt_s      = state_r;
      err_code_nxt_s   = err_code_r;
      prev_code_nxt_s  = bus.light;
      phase_done_nxt_s = 1'b0;
      count_inc_s      = 1'b0;
      if (change_s) begin
         run_len_nxt_s = RUN_ONE;
      end else if (run_len_r == RUN_MAX) begin
         run_len_nxt_s = run_len_r;
      end else begin
         run_len_nxt_s = run_len_r + RUN_ONE;
      end
      case (state_r)
         ST_UNSYNC: begin
            if ((bus.light == CODE_RED) && change_s) begin
               state_nxt_s = ST_TRACK;
            end else begin
               state_nxt_s = ST_UNSYNC;
            end
         end
         // checks use the run length before this sample updates it
         ST_TRACK: begin
            if (bus.light == CODE_ILLEGAL) begin
               state_nxt_s    = ST_FAULT;
               err_code_nxt_s = ERR_ILLEGAL;
            end else if (change_s && !legal_step(prev_code_r, bus.light)) begin
               state_nxt_s    = ST_FAULT;
               err_code_nxt_s = ERR_ORDER;
            end else if (change_s && (run_len_r != DWELL_RUN)) begin
               state_nxt_s    = ST_FAULT;
               err_code_nxt_s = ERR_DWELL;
            end else if (!change_s && (run_len_r == DWELL_RUN)) begin
               state_nxt_s    = ST_FAULT;
               err_code_nxt_s = ERR_DWELL;
            end else if (change_s) begin
               phase_done_nxt_s = 1'b1;
               count_inc_s      = (prev_code_r == CODE_YELLOW);
            end else begin
               state_nxt_s = ST_TRACK;
            end
         end
         ST_FAULT: begin
            if (bus.err_clear) begin
               state_nxt_s     = ST_UNSYNC;
               err_code_nxt_s  = ERR_NONE;
               prev_code_nxt_s = CODE_ILLEGAL;
            end else begin
               state_nxt_s = ST_FAULT;
            end
         end
         default: begin
            state_nxt_s    = ST_UNSYNC;
            err_code_nxt_s = ERR_NONE;
         end
      endcase
   end

   // State, history and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_UNSYNC;
         prev_code_r   <= CODE_ILLEGAL;
         run_len_r     <= {RUN_W{1'b0}};
         err_code_r    <= ERR_NONE;
         lamps_r       <= 3'b000;
         in_sync_r     <= 1'b0;
         phase_done_r  <= 1'b0;
         fault_r       <= 1'b0;
         cycle_count_r <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         prev_code_r  <= prev_code_nxt_s;
         run_len_r    <= run_len_nxt_s;
         err_code_r   <= err_code_nxt_s;
         in_sync_r    <= (state_nxt_s == ST_TRACK);
         phase_done_r <= phase_done_nxt_s;
         fault_r      <= (state_nxt_s == ST_FAULT);
         if (state_nxt_s == ST_FAULT) begin
            lamps_r <= 3'b100;
         end else begin
            lamps_r <= decode_lamps(bus.light);
         end
         if (count_inc_s) begin
            cycle_count_r <= cycle_count_r + CNT_ONE;
         end else begin
            cycle_count_r <= cycle_count_r;
         end
      end
   end

   assign bus.lamp_red    = lamps_r[2];
   assign bus.lamp_green  = lamps_r[1];
   assign bus.lamp_yellow = lamps_r[0];
   assign bus.in_sync     = in_sync_r;
   assign bus.phase_done  = phase_done_r;
   assign bus.fault       = fault_r;
   assign bus.err_code    = err_code_r;
   assign bus.cycle_count = cycle_count_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed vector bench for traffic_light_monitor; a second instance with a
// 2-bit cycle counter checks counter wrap.
module tb_traffic_light_monitor;

   typedef struct packed {
      logic [1:0] light;
      logic       clr;
      logic [2:0] lamps;
      logic       sync;
      logic       pd;
      logic       flt;
      logic [1:0] ec;
      logic [7:0] cnt;
   } vec_t;

   localparam logic [2:0] L_R = 3'b100;
   localparam logic [2:0] L_G = 3'b010;
   localparam logic [2:0] L_Y = 3'b001;
   localparam logic [2:0] L_0 = 3'b000;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   traffic_light_if #(.CNT_W(8)) bus  ();
   traffic_light_if #(.CNT_W(2)) bus2 ();

   traffic_light_monitor #(.DWELL(4), .RUN_W(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   traffic_light_monitor #(.DWELL(4), .RUN_W(4), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] obs1();
      return {bus.lamp_red, bus.lamp_green, bus.lamp_yellow, bus.in_sync,
              bus.phase_done, bus.fault, bus.err_code, bus.cycle_count};
   endfunction

   function automatic logic [15:0] obs2();
      return {bus2.lamp_red, bus2.lamp_green, bus2.lamp_yellow, bus2.in_sync,
              bus2.phase_done, bus2.fault, bus2.err_code, 6'd0, bus2.cycle_count};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h (lamps/sync/pd/fault/err/count)", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] lt, input logic clr);
      bus.light      = lt;
      bus.err_clear  = clr;
      bus2.light     = lt;
      bus2.err_clear = clr;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic [1:0] lt, input logic clr, input logic [2:0] lamps,
                               input logic sync, input logic pd, input logic flt,
                               input logic [1:0] ec, input logic [7:0] cnt);
      vec_t v;
      v.light = lt; v.clr = clr; v.lamps = lamps; v.sync = sync;
      v.pd = pd; v.flt = flt; v.ec = ec; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   function automatic logic [2:0] lamp_of(input logic [1:0] code);
      return (code == 2'd0) ? L_R : (code == 2'd1) ? L_G : (code == 2'd2) ? L_Y : L_0;
   endfunction

   initial begin
      logic [7:0] cnt;
      logic [1:0] code;
      logic [1:0] exp_wrap [4];
      checks = 0;
      errors = 0;
      exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0};

      // Test 1: three full legal cycles, then red
      cnt = 8'd0;
      for (int rep = 0; rep < 3; rep++) begin
         for (int ph = 0; ph < 3; ph++) begin
            code = 2'(ph);
            for (int k = 0; k < 4; k++) begin
               if (ph == 0 && k == 0 && rep > 0) cnt = cnt + 8'd1;
               add(code, 1'b0, lamp_of(code), 1'b1,
                   (k == 0) && !(rep == 0 && ph == 0), 1'b0, 2'd0, cnt);
            end
         end
      end
      add(2'd0, 1'b0, L_R, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
      // Test 3: R x4 then Y -> bad order; fault held; clear
      for (int k = 0; k < 3; k++) add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd2, 1'b0, L_R, 1'b0, 1'b0, 1'b1, 2'd2, 8'd3);
      add(2'd1, 1'b0, L_R, 1'b0, 1'b0, 1'b1, 2'd2, 8'd3);
      add(2'd2, 1'b1, L_Y, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3);
      // Test 2: sync, illegal code in G phase, clear on red, fresh red resyncs
      add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      for (int k = 0; k < 3; k++) add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd3, 1'b0, L_R, 1'b0, 1'b0, 1'b1, 2'd1, 8'd3);
      add(2'd0, 1'b1, L_R, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      // Test 4: G x3 then Y (too short); then G x5 (stuck)
      for (int k = 0; k < 3; k++) add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd2, 1'b0, L_R, 1'b0, 1'b0, 1'b1, 2'd3, 8'd3);
      add(2'd3, 1'b1, L_0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      for (int k = 0; k < 3; k++) add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_G, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
      for (int k = 0; k < 3; k++) add(2'd1, 1'b0, L_G, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd1, 1'b0, L_R, 1'b0, 1'b0, 1'b1, 2'd3, 8'd3);
      // Test 5: clear wins over same-cycle violation; clear outside FAULT is ignored
      add(2'd3, 1'b1, L_0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd0, 1'b1, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd0, 1'b1, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);
      add(2'd0, 1'b0, L_R, 1'b1, 1'b0, 1'b0, 2'd0, 8'd3);

      // Reset state
      reset = 1'b1;
      step(2'd0, 1'b0);
      check("reset_state", obs1(), 16'h0000);
      reset = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].light, vecs[i].clr);
         check($sformatf("vec%0d", i), obs1(),
               {vecs[i].lamps, vecs[i].sync, vecs[i].pd, vecs[i].flt, vecs[i].ec, vecs[i].cnt});
      end

      // Reset mid-TRACK clears everything, including the cycle counter
      reset = 1'b1;
      step(2'd1, 1'b0);
      check("midreset", obs1(), 16'h0000);
      check("midreset_w", obs2(), 16'h0000);
      reset = 1'b0;

      // Test 6: four full cycles on a 2-bit counter wrap 1,2,3,0
      for (int c = 0; c < 4; c++) begin
         for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 4; k++) begin
               step(2'(ph), 1'b0);
               if (ph == 0 && k == 0 && c > 0)
                  check($sformatf("wrap%0d", c), {14'd0, bus2.cycle_count}, {14'd0, exp_wrap[c-1]});
            end
         end
         check($sformatf("wrap_nofault%0d", c), {15'd0, bus2.fault}, 16'd0);
      end
      step(2'd0, 1'b0);
      check("wrap3", {14'd0, bus2.cycle_count}, {14'd0, exp_wrap[3]});
      check("wrap_pd", {15'd0, bus2.phase_done}, 16'd1);
      check("wide_cnt", {8'd0, bus.cycle_count}, 16'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
